// File: rtl/mux_ctrl_seq.sv
// mux_ctrl_seq: symbol mux sequencer framing TLPs with STP/DATA/END (or EDB on abort).
// Define SKP_INSERT_EN to add periodic SKP ordered-set insertion from IDLE.
module mux_ctrl_seq #(
    parameter int unsigned SKP_INTERVAL = 64
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tlp_req,
    input  logic [3:0] tlp_len,
    input  logic       tlp_abort,
    output logic       tlp_ack,
    output logic       tlp_rd,
    output logic [3:0] ctrl_out,
    output logic       ctrl_vld,
    output logic       busy
);

    // state    | meaning
    // IDLE     | idle symbols, samples tlp_req (and skp_pending)
    // STP      | start-of-TLP framing symbol, one cycle
    // DATA     | TLP bytes, one per cycle, cnt counts down the latched length
    // END      | good end framing symbol, one cycle
    // EDB      | aborted-packet end symbol, one cycle
    // SKP_COM  | COM of the SKP ordered set, one cycle
    // SKP_SYM  | SKP symbols, three cycles
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_STP     = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_END     = 3'd3;
    localparam logic [2:0] ST_EDB     = 3'd4;
`ifdef SKP_INSERT_EN
    localparam logic [2:0] ST_SKP_COM = 3'd5;
    localparam logic [2:0] ST_SKP_SYM = 3'd6;
`endif

    localparam logic [3:0] SEL_TLP = 4'd0;
    localparam logic [3:0] SEL_STP = 4'd4;
    localparam logic [3:0] SEL_END = 4'd6;
    localparam logic [3:0] SEL_EDB = 4'd7;
    localparam logic [3:0] SEL_IDL = 4'd9;
`ifdef SKP_INSERT_EN
    localparam logic [3:0] SEL_COM = 4'd1;
    localparam logic [3:0] SEL_SKP = 4'd3;
`endif

    logic [2:0] state, next_state;
    logic [4:0] cnt, cnt_nxt;

    function automatic logic [3:0] sel_of(input logic [2:0] s);
        case (s)
            ST_STP:     sel_of = SEL_STP;
            ST_DATA:    sel_of = SEL_TLP;
            ST_END:     sel_of = SEL_END;
            ST_EDB:     sel_of = SEL_EDB;
`ifdef SKP_INSERT_EN
            ST_SKP_COM: sel_of = SEL_COM;
            ST_SKP_SYM: sel_of = SEL_SKP;
`endif
            default:    sel_of = SEL_IDL;
        endcase
    endfunction

`ifdef SKP_INSERT_EN
    localparam logic [7:0] SKP_RELOAD = 8'(SKP_INTERVAL);

    logic [7:0] skp_cnt;
    logic       skp_pending;
    logic       skp_expire;

    assign skp_expire = (skp_cnt == 8'd1);

    // Free-running interval down-counter; expiry re-arms the flag even mid ordered set.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            skp_cnt     <= 8'd0;
            skp_pending <= 1'b0;
        end else begin
            skp_cnt <= (skp_cnt <= 8'd1) ? SKP_RELOAD : skp_cnt - 8'd1;
            if (skp_expire)
                skp_pending <= 1'b1;
            else if (state == ST_IDLE && next_state == ST_SKP_COM)
                skp_pending <= 1'b0;
        end
    end
`endif

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            ST_IDLE: begin
`ifdef SKP_INSERT_EN
                if (skp_pending)
                    next_state = ST_SKP_COM;
                else
`endif
                if (tlp_req) begin
                    next_state = ST_STP;
                    cnt_nxt    = (tlp_len == 4'd0) ? 5'd16 : {1'b0, tlp_len};
                end
            end
            ST_STP: next_state = ST_DATA;
            ST_DATA: begin
                // Abort on the final byte is too late to matter: the packet completes.
                if (cnt == 5'd1) begin
                    next_state = ST_END;
                    cnt_nxt    = 5'd0;
                end else if (tlp_abort) begin
                    next_state = ST_EDB;
                    cnt_nxt    = 5'd0;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
            ST_END: next_state = ST_IDLE;
            ST_EDB: next_state = ST_IDLE;
`ifdef SKP_INSERT_EN
            ST_SKP_COM: begin
                next_state = ST_SKP_SYM;
                cnt_nxt    = 5'd3;
            end
            ST_SKP_SYM: begin
                if (cnt == 5'd1) begin
                    next_state = ST_IDLE;
                    cnt_nxt    = 5'd0;
                end else begin
                    cnt_nxt = cnt - 5'd1;
                end
            end
`endif
            default: begin
                next_state = ST_IDLE;
                cnt_nxt    = 5'd0;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 5'd0;
            tlp_ack  <= 1'b0;
            tlp_rd   <= 1'b0;
            ctrl_out <= SEL_IDL;
            ctrl_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_nxt;
            tlp_ack  <= (state == ST_IDLE) && (next_state == ST_STP);
            tlp_rd   <= (next_state == ST_DATA);
            ctrl_out <= sel_of(next_state);
            ctrl_vld <= (next_state != ST_IDLE);
            busy     <= (next_state != ST_IDLE);
        end
    end

endmodule
